// File: rtl/fifo_pkg.sv
// Shared sizing helpers and the pointer wrap rule for the synchronous FIFO.
// The operation enum names what one clock edge does to the occupancy count.
package fifo_pkg;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

    // Pointer width for a given depth; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Count width: must hold the value DEPTH itself, not just DEPTH-1.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Increment with an explicit wrap so non-power-of-two depths work.
    function automatic int unsigned ptr_wrap(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Circular index for the FIFO storage; advances by one on inc and wraps
// from DEPTH-1 back to 0.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      inc,
    output logic [$clog2(DEPTH)-1:0]  ptr
);

    localparam int PW = $clog2(DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= PW'(ptr_wrap(32'(ptr), DEPTH));
        end
    end

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO using every storage slot; status flags come from the
// occupancy count rather than from a pointer comparison.
module fifo_sync
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 5,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]    w_ptr;
    logic [PW-1:0]    r_ptr;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] rd_data_reg;
    logic             overflow_reg;
    logic             underflow_reg;
    logic             wr_ok;
    logic             rd_ok;
    fifo_op_e         op;

    logic [WIDTH-1:0] mem [DEPTH];

    // A write into a full FIFO is still taken when a read frees a slot on
    // the same edge; a read from an empty FIFO is never taken.
    always_comb begin
        wr_ok = wr_en && (!full || rd_en);
        rd_ok = rd_en && !empty;
        op    = OP_IDLE;
        if (wr_ok && rd_ok) begin
            op = OP_BOTH;
        end else if (wr_ok) begin
            op = OP_WRITE;
        end else if (rd_ok) begin
            op = OP_READ;
        end
    end

    always_comb begin
        count_next = count_reg;
        case (op)
            OP_WRITE: count_next = count_reg + CW'(1);
            OP_READ:  count_next = count_reg - CW'(1);
            default:  count_next = count_reg;
        endcase
    end

    fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (wr_ok),
        .ptr (w_ptr)
    );

    fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (rd_ok),
        .ptr (r_ptr)
    );

    // Storage carries no reset; its contents are only observable via rd_data.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[w_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg     <= '0;
            rd_data_reg   <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            count_reg     <= count_next;
            overflow_reg  <= wr_en && !wr_ok;
            underflow_reg <= rd_en && !rd_ok;
            if (rd_ok) begin
                rd_data_reg <= mem[r_ptr];
            end
        end
    end

    assign count        = count_reg;
    assign rd_data      = rd_data_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;
    assign full         = (count_reg == CW'(DEPTH));
    assign empty        = (count_reg == '0);
    assign almost_full  = (count_reg >= CW'(AF_LEVEL));
    assign almost_empty = (count_reg <= CW'(AE_LEVEL));

endmodule

// File: tb/tb_fifo_sync.sv
// Bench for fifo_sync: directed scenarios plus a randomized run, all checked
// against a queue-based occupancy model.
module tb_fifo_sync;

    localparam int WIDTH = 8;
    localparam int DEPTH = 5;
    localparam int AF    = 4;
    localparam int AE    = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_en = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             rd_en = 1'b0;
    logic [WIDTH-1:0] rd_data;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [2:0]       count;
    logic             overflow;
    logic             underflow;

    int errors = 0;
    int checks = 0;

    logic [7:0] q[$];
    logic [7:0] exp_rd = 8'h00;
    bit         exp_ovf = 1'b0;
    bit         exp_unf = 1'b0;
    int         wr_total = 0;
    int         rd_total = 0;

    fifo_sync #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // One transaction: drive, let one edge pass, update the model, sample at edge+1.
    task automatic cycle(input bit w, input logic [7:0] d, input bit r);
        bit wacc;
        bit racc;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        wacc = w && ((q.size() < DEPTH) || r);
        racc = r && (q.size() > 0);
        @(posedge clk);
        if (racc) begin
            exp_rd = q.pop_front();
            rd_total++;
        end
        if (wacc) begin
            q.push_back(d);
            wr_total++;
        end
        exp_ovf = w && !wacc;
        exp_unf = r && !racc;
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        $display("txn t=%0t wr=%0d data=%02h rd=%0d | count=%0d rd_data=%02h ovf=%0d unf=%0d",
                 $time, w, d, r, count, rd_data, overflow, underflow);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (empty !== 1'b1 || almost_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got e=%0b ae=%0b want 1/1", empty, almost_empty); end
        checks++; if (full !== 1'b0 || almost_full !== 1'b0) begin errors++; $display("FAIL reset_full: got f=%0b af=%0b want 0/0", full, almost_full); end
        checks++; if (rd_data !== 8'h00 || overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_outputs: got rd=%02h ovf=%0b unf=%0b want 00/0/0", rd_data, overflow, underflow); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 8'(8'h10 + i), 1'b0);
            checks++; if (count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1); end
            checks++; if (almost_full !== ((i + 1) >= AF)) begin errors++; $display("FAIL fill_almost_full[%0d]: got %0b want %0b", i, almost_full, (i + 1) >= AF); end
            checks++; if (full !== (i == DEPTH - 1)) begin errors++; $display("FAIL fill_full[%0d]: got %0b want %0b", i, full, i == DEPTH - 1); end
        end
        cycle(1'b1, 8'h15, 1'b0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow: got %0b want 1", overflow); end
        checks++; if (count !== 3'd5) begin errors++; $display("FAIL fill_overflow_count: got %0d want 5", count); end
        cycle(1'b0, 8'h00, 1'b0);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_overflow_pulse: got %0b want 0", overflow); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
            checks++; if (rd_data !== 8'(8'h10 + i)) begin errors++; $display("FAIL drain_data[%0d]: got %02h want %02h", i, rd_data, 8'(8'h10 + i)); end
            checks++; if (count !== 3'(DEPTH - 1 - i)) begin errors++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, count, DEPTH - 1 - i); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %0b want 1", empty); end
        cycle(1'b0, 8'h00, 1'b1);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL drain_underflow: got %0b want 1", underflow); end
        checks++; if (rd_data !== 8'h14) begin errors++; $display("FAIL drain_hold: got %02h want 14", rd_data); end
        cycle(1'b0, 8'h00, 1'b0);
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL drain_underflow_pulse: got %0b want 0", underflow); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, 8'(8'h20 + i), 1'b0);
            checks++; if (count !== 3'd1) begin errors++; $display("FAIL wrap_count_w[%0d]: got %0d want 1", i, count); end
            checks++; if (dut.w_ptr !== 3'(wr_total % DEPTH)) begin errors++; $display("FAIL wrap_wptr[%0d]: got %0d want %0d", i, dut.w_ptr, wr_total % DEPTH); end
            cycle(1'b0, 8'h00, 1'b1);
            checks++; if (count !== 3'd0) begin errors++; $display("FAIL wrap_count_r[%0d]: got %0d want 0", i, count); end
            checks++; if (rd_data !== 8'(8'h20 + i)) begin errors++; $display("FAIL wrap_data[%0d]: got %02h want %02h", i, rd_data, 8'(8'h20 + i)); end
            checks++; if (dut.r_ptr !== 3'(rd_total % DEPTH)) begin errors++; $display("FAIL wrap_rptr[%0d]: got %0d want %0d", i, dut.r_ptr, rd_total % DEPTH); end
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL simul_prefull: got %0b want 1", full); end
        cycle(1'b1, 8'hA5, 1'b1);
        checks++; if (count !== 3'd5 || overflow !== 1'b0) begin errors++; $display("FAIL simul_full: got count=%0d ovf=%0b want 5/0", count, overflow); end
        checks++; if (rd_data !== exp_rd) begin errors++; $display("FAIL simul_full_data: got %02h want %02h", rd_data, exp_rd); end
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1);
        checks++; if (rd_data !== 8'hA5) begin errors++; $display("FAIL simul_last_data: got %02h want a5", rd_data); end
        cycle(1'b1, 8'h5A, 1'b1);
        checks++; if (count !== 3'd1 || underflow !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL simul_empty: got count=%0d unf=%0b ovf=%0b want 1/1/0", count, underflow, overflow); end
        cycle(1'b0, 8'h00, 1'b1);
        checks++; if (rd_data !== 8'h5A) begin errors++; $display("FAIL simul_empty_data: got %02h want 5a", rd_data); end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'($urandom_range(0, 127)) | 8'h80, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        checks++; if (count !== 3'd3 || rd_data !== exp_rd) begin errors++; $display("FAIL mid_pre: got count=%0d rd=%02h want 3/%02h", count, rd_data, exp_rd); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (count !== 3'd0 || empty !== 1'b1 || rd_data !== 8'h00) begin errors++; $display("FAIL mid_async: got count=%0d empty=%0b rd=%02h want 0/1/00", count, empty, rd_data); end
        wr_en = 1'b1;
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (count !== 3'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL mid_ignore: got count=%0d ovf=%0b unf=%0b want 0/0/0", count, overflow, underflow); end
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2;
        rst = 1'b0;
        q.delete();
        exp_rd   = 8'h00;
        wr_total = 0;
        rd_total = 0;
        checks++; if (dut.w_ptr !== 3'd0 || dut.r_ptr !== 3'd0) begin errors++; $display("FAIL mid_ptrs: got w=%0d r=%0d want 0/0", dut.w_ptr, dut.r_ptr); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            int wp;
            wp = (n < 150) ? 60 : 40;
            cycle(($urandom_range(0, 99) < wp), 8'($urandom_range(0, 255)), ($urandom_range(0, 99) < (100 - wp)));
            checks++; if (count !== 3'(q.size())) begin errors++; $display("FAIL rand_count[%0d]: got %0d want %0d", n, count, q.size()); end
            checks++; if (full !== (q.size() == DEPTH) || empty !== (q.size() == 0)) begin errors++; $display("FAIL rand_full_empty[%0d]: got f=%0b e=%0b size=%0d", n, full, empty, q.size()); end
            checks++; if (almost_full !== (q.size() >= AF) || almost_empty !== (q.size() <= AE)) begin errors++; $display("FAIL rand_almost[%0d]: got af=%0b ae=%0b size=%0d", n, almost_full, almost_empty, q.size()); end
            checks++; if (rd_data !== exp_rd) begin errors++; $display("FAIL rand_data[%0d]: got %02h want %02h", n, rd_data, exp_rd); end
            checks++; if (overflow !== exp_ovf || underflow !== exp_unf) begin errors++; $display("FAIL rand_pulses[%0d]: got ovf=%0b unf=%0b want %0b/%0b", n, overflow, underflow, exp_ovf, exp_unf); end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simultaneous();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
